// File: rtl/muller_pkg.sv
// Shared mode encodings for the Muller C-element array.
package muller_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SYM    = 2'b00;
  localparam mode_t MODE_ASYM   = 2'b01;
  localparam mode_t MODE_FREEZE = 2'b10;
  localparam mode_t MODE_BYPASS = 2'b11;

endpackage

// File: rtl/muller_c_cell.sv
// One generalised C-element channel: registered output, edge pulses, saturating transition counter.
// Inputs are expected to be already synchronised; output updates one edge after s_i.
module muller_c_cell
  import muller_pkg::*;
#(
  parameter int              N_IN      = 3,
  parameter logic [N_IN-1:0] PLUS_MASK = 3'b100,
  parameter logic            RST_VAL   = 1'b0,
  parameter int              CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IN-1:0]  s_i,
  input  mode_t            mode_i,
  input  logic             clr_i,
  output logic             c_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] tcnt_o
);

  logic             c_q, c_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    c_d = c_q;
    case (mode_i)
      MODE_SYM: begin
        if (&s_i)       c_d = 1'b1;
        else if (~|s_i) c_d = 1'b0;
      end
      MODE_ASYM: begin
        // plus inputs only gate the rise; the fall looks at the minus inputs alone
        if (&s_i)                     c_d = 1'b1;
        else if (~|(s_i & ~PLUS_MASK)) c_d = 1'b0;
      end
      MODE_BYPASS: c_d = s_i[0];
      default:     c_d = c_q;
    endcase

    rise_d = c_d & ~c_q;
    fall_d = ~c_d & c_q;

    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if ((c_d != c_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q    <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      c_q    <= c_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign c_o    = c_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign tcnt_o = cnt_q;

endmodule

// File: rtl/muller_c_array.sv
// Array of NUM_CH clocked C-elements behind SYNC_STAGES-deep input synchronisers.
// Latency from a stable input change to c_o is SYNC_STAGES+1 edges.
module muller_c_array
  import muller_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              N_IN        = 3,
  parameter logic [N_IN-1:0] PLUS_MASK   = 3'b100,
  parameter logic            RST_VAL     = 1'b0,
  parameter int              SYNC_STAGES = 2,
  parameter int              CNT_W       = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_CH*N_IN-1:0]    in_i,
  input  logic [2*NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]         clr_cnt_i,
  output logic [NUM_CH-1:0]         c_o,
  output logic [NUM_CH-1:0]         rise_o,
  output logic [NUM_CH-1:0]         fall_o,
  output logic [NUM_CH*CNT_W-1:0]   tcnt_o
);

  localparam int W = NUM_CH * N_IN;

  if (N_IN < 2) begin : g_err_nin
    $error("muller_c_array: N_IN must be at least 2");
  end
  if (SYNC_STAGES < 1) begin : g_err_sync
    $error("muller_c_array: SYNC_STAGES must be at least 1");
  end
  if (PLUS_MASK == {N_IN{1'b1}}) begin : g_err_mask
    $error("muller_c_array: PLUS_MASK must not be all ones");
  end

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;

  always_comb begin
    sync_d[0] = in_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Reset fills the chain with RST_VAL so release never looks like an input edge
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) sync_q <= {(SYNC_STAGES*W){RST_VAL}};
    else          sync_q <= sync_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    muller_c_cell #(
      .N_IN      (N_IN),
      .PLUS_MASK (PLUS_MASK),
      .RST_VAL   (RST_VAL),
      .CNT_W     (CNT_W)
    ) u_cell (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .s_i    (sync_q[SYNC_STAGES-1][k*N_IN +: N_IN]),
      .mode_i (mode_t'(mode_i[2*k +: 2])),
      .clr_i  (clr_cnt_i[k]),
      .c_o    (c_o[k]),
      .rise_o (rise_o[k]),
      .fall_o (fall_o[k]),
      .tcnt_o (tcnt_o[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/muller_c_array.md
# muller_c_array

Parametrised, clocked array of generalised Muller C-elements. It is the successor to the fixed 3-input C-element project on the 6-bit `io_in` bus. It adds:
- `NUM_CH` independent channels of `N_IN` inputs each
- per-channel mode (symmetric, asymmetric, freeze, bypass)
- input synchronisers
- per-channel saturating transition counters

It sits between the user-project IO pads and the async test logic.

## Interface
- `NUM_CH`, 4, number of independent C-element channels
- `N_IN`, 3, inputs per channel (≥2)
- `PLUS_MASK`, 3'b100, `N_IN`-bit mask; set bits are "plus" inputs in ASYM mode (must not be all ones)
- `RST_VAL`, 1'b0, reset value of every `c_o` bit
- `SYNC_STAGES`, 2, synchroniser flops per input (≥1)
- `CNT_W`, 8, transition-counter width

- `wb_clk_i`  in  1  clock; one clock domain
- `wb_rst_i`  in  1  reset; synchronous and active-high
- `in_i`  in  `NUM_CH*N_IN`  raw inputs; channel k uses bits `[k*N_IN +: N_IN]`
- `mode_i`  in  `2*NUM_CH`  per-channel mode: 00 SYM, 01 ASYM, 10 FREEZE, 11 BYPASS
- `clr_cnt_i`  in  `NUM_CH`  per-channel counter clear
- `c_o`  out  `NUM_CH`  C-element outputs (registered)
- `rise_o`  out  `NUM_CH`  one-cycle pulse when `c_o` goes 0→1
- `fall_o`  out  `NUM_CH`  one-cycle pulse when `c_o` goes 1→0
- `tcnt_o`  out  `NUM_CH*CNT_W`  saturating transition count per channel

## Operation
- Each `in_i` bit passes through `SYNC_STAGES` flops. Evaluation uses only the final synchronised value `s`.
- **SYM:** next = 1 if all `s` = 1; 0 if all `s` = 0; else hold.
- **ASYM:**
  - next = 1 if all `s` = 1.
  - next = 0 if every non-plus input is 0; plus inputs are ignored for the fall.
  - Else hold.
- **FREEZE:** hold `c_o` regardless of inputs.
- **BYPASS:** next = `s[0]` of the channel.
- **Mode change:** takes effect on the next evaluation edge. `c_o` is never reset by a mode change; the new mode evaluates from the held value.
- **Pulses:** `rise_o`/`fall_o` assert in the same cycle `c_o` shows the new value, for exactly one cycle.
- **Counter:** increments by 1 on every `c_o` change. It saturates at 2^`CNT_W`−1 and does not wrap.
- **Counter clear:** `clr_cnt_i[k]` sets the count to 0 on the next edge. Clear wins over a simultaneous increment, so the count is 0, not 1.
- **Elaboration checks:** `PLUS_MASK` all ones, `N_IN`<2 or `SYNC_STAGES`<1 → elaboration-time `$error`.

## Timing
- **Latency:** an input change stable before edge 0 appears on `c_o` after edge `SYNC_STAGES`+1, i.e. 3 edges by default. Pulses and counter update on the same edge.
- **Reset:** `wb_rst_i` high at an edge forces:
  - all synchroniser flops to `RST_VAL`, so no spurious transition occurs after release
  - `c_o` = `RST_VAL`
  - `rise_o` = `fall_o` = 0
  - `tcnt_o` = 0
- **Reset mid-operation:** in-flight synchroniser contents are discarded. The first evaluation after release uses `RST_VAL`-filled flops, so `c_o` is stable for `SYNC_STAGES` cycles after release.
- **Mode inputs:** `mode_i` and `clr_cnt_i` are synchronous and sampled directly, without synchronisation.
- **Simultaneous events:** an input change and a mode change on the same edge are evaluated with the new mode.

## Structure
- Shared package `muller_pkg`:
  - mode localparams `MODE_SYM`, `MODE_ASYM`, `MODE_FREEZE`, `MODE_BYPASS`
  - 2-bit mode type
- Sub-module `muller_c_cell`: one channel, containing the eval register, edge pulses and counter. Generic over `N_IN`, `PLUS_MASK`, `RST_VAL`, `CNT_W`.
- Top: the synchroniser array plus a generate loop of `NUM_CH` cells.
- Formal cover harness: instantiated on the 6-bit IO subset with `NUM_CH`=2, `N_IN`=3.

## Test plan
1. **Reset values:** reset with `RST_VAL`=0, then hold all `in_i`=0 → `c_o`=0, no pulses, `tcnt_o`=0 for 10 cycles. Repeat with `RST_VAL`=1 and `in_i` all 1 → `c_o`=1, no pulses.
2. **SYM:** ch0 inputs 000→111 → `c_o[0]`=1 exactly 3 edges later with a one-cycle `rise_o[0]`. Then 111→110 → hold at 1. Then →000 → `fall_o[0]` and `c_o[0]`=0; `tcnt`=2.
3. **ASYM (`PLUS_MASK`=100):** inputs 111 → `c_o`=1. Then 100 → `c_o` falls because the plus input is ignored. Then 011 → hold at 0.
4. **FREEZE / BYPASS:** FREEZE with toggling inputs → `c_o` constant and `tcnt` unchanged. BYPASS with `s[0]` toggling every 4 cycles → `c_o` follows after 3 edges and `tcnt` increments per toggle.
5. **Counter saturation and clear (`CNT_W`=2):**
   - 5 transitions → `tcnt`=3.
   - `clr_cnt_i` asserted on the same edge as a transition → `tcnt`=0.
6. **Reset mid-operation:** `wb_rst_i` asserted one cycle after an input edge while it is still in the synchroniser → no pulse after release, `c_o`=`RST_VAL`.
